button_conditioner: RTL and testbench

- Input-side counterpart to the display path: turns the raw board buttons and switches (PAUSE, RESET, SEL, ADJ) into clean, synchronous control signals for the stopwatch counter.
- Each input gets a 2-flop synchronizer and a counter-based debouncer.
- Buttons also produce one-cycle press pulses.
- Owns the run/pause toggle state.
- Sits between the board pins and the counter/clock-divider logic, in the master clk domain.

---
 rtl/button_conditioner.sv | 129 ++++++++++++
 tb/tb_button_conditioner.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/button_conditioner.sv
// Board button/switch front end: per-input 2-flop synchronizer and counter debouncer,
// press pulses for the buttons, and the stopwatch run/pause toggle.

module button_conditioner_lane #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W           = 20,
  parameter bit EDGE_OUT        = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic raw_i,
  output logic out_o
);
  logic             s1_q, s2_q;
  logic             stable_q, stable_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             accept;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q     <= 1'b0;
      s2_q     <= 1'b0;
      stable_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      s1_q     <= raw_i;
      s2_q     <= s1_q;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  // Counter only advances while the synchronized input disagrees; any agreement restarts it.
  always_comb begin
    stable_d = stable_q;
    cnt_d    = cnt_q;
    accept   = 1'b0;
    if (s2_q == stable_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
      stable_d = s2_q;
      cnt_d    = '0;
      accept   = 1'b1;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Button lanes export the 0->1 accept strobe (combinational, same edge as the level change);
  // switch lanes export the debounced level.
  generate
    if (EDGE_OUT) begin : g_edge
      assign out_o = accept & s2_q;
    end else begin : g_level
      assign out_o = stable_q;
    end
  endgenerate
endmodule

module button_conditioner #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W           = 20
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_pause_raw,
  input  logic btn_reset_raw,
  input  logic sw_sel_raw,
  input  logic sw_adj_raw,
  output logic sel,
  output logic adj,
  output logic reset_pulse,
  output logic pause_pulse,
  output logic paused
);
  localparam int NUM_IN  = 4;
  localparam int NUM_BTN = 2;
  localparam int I_PAUSE = 0;
  localparam int I_RESET = 1;
  localparam int I_SEL   = 2;
  localparam int I_ADJ   = 3;

  logic [NUM_IN-1:0] raw;
  logic [NUM_IN-1:0] lane_out;
  logic              reset_pulse_q, pause_pulse_q;
  logic              paused_q, paused_d;

  assign raw = {sw_adj_raw, sw_sel_raw, btn_reset_raw, btn_pause_raw};

  // Buttons occupy the low lanes so the lane index alone selects pulse vs level output.
  generate
    for (genvar g = 0; g < NUM_IN; g++) begin : g_lane
      button_conditioner_lane #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .CNT_W          (CNT_W),
        .EDGE_OUT       (g < NUM_BTN)
      ) u_lane (
        .clk  (clk),
        .rst  (rst),
        .raw_i(raw[g]),
        .out_o(lane_out[g])
      );
    end
  endgenerate

  always_comb begin
    paused_d = paused_q;
    if (lane_out[I_RESET])      paused_d = 1'b0;
    else if (lane_out[I_PAUSE]) paused_d = ~paused_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      reset_pulse_q <= 1'b0;
      pause_pulse_q <= 1'b0;
      paused_q      <= 1'b0;
    end else begin
      reset_pulse_q <= lane_out[I_RESET];
      pause_pulse_q <= lane_out[I_PAUSE];
      paused_q      <= paused_d;
    end
  end

  assign sel         = lane_out[I_SEL];
  assign adj         = lane_out[I_ADJ];
  assign reset_pulse = reset_pulse_q;
  assign pause_pulse = pause_pulse_q;
  assign paused      = paused_q;
endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner with a window-based reference model checked every cycle.

module tb_button_conditioner;
  localparam int D = 4;
  localparam int W = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic bp = 1'b0, br = 1'b0, ss = 1'b0, sa = 1'b0;
  logic sel, adj, reset_pulse, pause_pulse, paused;

  int n_chk = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  button_conditioner #(.DEBOUNCE_CYCLES(D), .CNT_W(W)) dut (
    .clk          (clk),
    .rst          (rst),
    .btn_pause_raw(bp),
    .btn_reset_raw(br),
    .sw_sel_raw   (ss),
    .sw_adj_raw   (sa),
    .sel          (sel),
    .adj          (adj),
    .reset_pulse  (reset_pulse),
    .pause_pulse  (pause_pulse),
    .paused       (paused)
  );

  task automatic chk(input string nm, input logic act, input logic exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b", nm, act, exp);
  endtask

  // Reference: a level flips once the last D synchronized samples (raw delayed two edges)
  // all disagree with it. bit0 pause, bit1 reset, bit2 sel, bit3 adj.
  logic [3:0] samp[$];
  logic [3:0] m_stable = '0;
  logic       m_rp = 1'b0, m_pp = 1'b0, m_paused = 1'b0;

  always @(posedge clk or posedge rst) begin : model
    logic [3:0] nst;
    logic [3:0] rise;
    logic       flip;
    if (rst) begin
      samp.delete();
      repeat (D + 2) samp.push_back(4'b0);
      m_stable <= '0;
      m_rp     <= 1'b0;
      m_pp     <= 1'b0;
      m_paused <= 1'b0;
    end else begin
      samp.push_front({sa, ss, br, bp});
      void'(samp.pop_back());
      nst  = m_stable;
      rise = '0;
      for (int b = 0; b < 4; b++) begin
        flip = 1'b1;
        for (int j = 2; j <= D + 1; j++)
          if (samp[j][b] == m_stable[b]) flip = 1'b0;
        if (flip) begin
          nst[b]  = ~m_stable[b];
          rise[b] = ~m_stable[b];
        end
      end
      m_stable <= nst;
      m_pp     <= rise[0];
      m_rp     <= rise[1];
      m_paused <= rise[1] ? 1'b0 : (rise[0] ? ~m_paused : m_paused);
    end
  end

  always @(negedge clk) begin
    chk("model_sel", sel, m_stable[2]);
    chk("model_adj", adj, m_stable[3]);
    chk("model_reset_pulse", reset_pulse, m_rp);
    chk("model_pause_pulse", pause_pulse, m_pp);
    chk("model_paused", paused, m_paused);
  end

  task automatic edges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string nm, input logic [4:0] exp);
    chk({nm, "_sel"}, sel, exp[4]);
    chk({nm, "_adj"}, adj, exp[3]);
    chk({nm, "_rp"}, reset_pulse, exp[2]);
    chk({nm, "_pp"}, pause_pulse, exp[1]);
    chk({nm, "_paused"}, paused, exp[0]);
  endtask

  initial begin
    // 1: reset with all inputs high, then release
    bp = 1'b1; br = 1'b1; ss = 1'b1; sa = 1'b1;
    for (int i = 0; i < 10; i++) begin
      edges(1);
      chk_all("rst_hold", 5'b00000);
    end
    rst = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      edges(1);
      chk_all("rel_early", 5'b00000);
    end
    edges(1);
    chk_all("rel_edge6", 5'b11110);
    edges(1);
    chk_all("rel_edge7", 5'b11000);
    bp = 1'b0; br = 1'b0; ss = 1'b0; sa = 1'b0;
    edges(12);
    chk_all("idle", 5'b00000);

    // 2: clean presses toggle paused
    bp = 1'b1;
    edges(5);
    chk("press1_e5_pp", pause_pulse, 1'b0);
    edges(1);
    chk("press1_e6_pp", pause_pulse, 1'b1);
    chk("press1_e6_paused", paused, 1'b1);
    edges(1);
    chk("press1_e7_pp", pause_pulse, 1'b0);
    for (int i = 0; i < 18; i++) begin
      edges(1);
      chk("press1_hold_pp", pause_pulse, 1'b0);
    end
    bp = 1'b0;
    edges(10);
    chk("release_paused", paused, 1'b1);
    bp = 1'b1;
    edges(6);
    chk("press2_e6_pp", pause_pulse, 1'b1);
    chk("press2_e6_paused", paused, 1'b0);
    edges(15);
    bp = 1'b0;
    edges(10);

    // 3: bounce, then settle high
    for (int i = 0; i < 8; i++) begin
      bp = (i % 2 == 0);
      repeat (2) begin
        edges(1);
        chk("bounce_pp", pause_pulse, 1'b0);
      end
    end
    bp = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      edges(1);
      chk("settle_early_pp", pause_pulse, 1'b0);
    end
    edges(1);
    chk("settle_e6_pp", pause_pulse, 1'b1);
    chk("settle_e6_paused", paused, 1'b1);
    edges(1);
    chk("settle_e7_pp", pause_pulse, 1'b0);
    bp = 1'b0;
    edges(10);

    // 4: three-cycle glitch on SEL is rejected
    ss = 1'b1;
    edges(3);
    ss = 1'b0;
    for (int i = 0; i < 12; i++) begin
      edges(1);
      chk("glitch_sel", sel, 1'b0);
    end

    // 5: simultaneous RESET and PAUSE while paused
    chk("prio_pre_paused", paused, 1'b1);
    bp = 1'b1; br = 1'b1;
    edges(5);
    chk_all("prio_e5", 5'b00001);
    edges(1);
    chk_all("prio_e6", 5'b00110);
    edges(1);
    chk_all("prio_e7", 5'b00000);
    bp = 1'b0; br = 1'b0;
    edges(10);

    // 6: reset mid-count restarts debouncing
    bp = 1'b1;
    edges(3);
    rst = 1'b1;
    #1;
    chk_all("mid_rst_async", 5'b00000);
    edges(1);
    chk_all("mid_rst_hold", 5'b00000);
    rst = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      edges(1);
      chk("mid_rel_early_pp", pause_pulse, 1'b0);
    end
    edges(1);
    chk("mid_rel_e6_pp", pause_pulse, 1'b1);
    chk("mid_rel_e6_paused", paused, 1'b1);
    edges(1);
    chk("mid_rel_e7_pp", pause_pulse, 1'b0);
    bp = 1'b0;
    edges(5);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
